// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder: the memory end of the IF-stage fetch port,
// plus a byte-serial program loader used by the host (testbench/debug) side
// to fill the word array.
//
// Fetch side (purely combinational):
//   imem_addr_i    fetch byte address from the IF stage
//   imem_rdata_o   fetch data; halfword-aligned addresses with addr[1]=1
//                  return the upper half of word w and the lower half of w+1
//   fetch_fault_o  misaligned, out-of-range, or a 32-bit instruction that
//                  would straddle past the last word
//
// Loader side (synchronous to clk_i):
//   clk_i          clock, all state updates on the rising edge
//   rst_n_i        synchronous active-low reset
//   load_start_i   opens a session (IDLE only), load_addr_i gives the start
//   load_addr_i    session start byte address, bits[1:0] ignored
//   load_valid_i   byte valid
//   load_byte_i    byte, little-endian within each word
//   load_last_i    marks the final byte of the session (with load_valid_i)
//   load_ready_o   a byte is accepted this cycle when valid is also high
//   load_busy_o    session (or array clear) in progress
//   load_done_o    one-cycle pulse at session end
//
// Optional feature, macro IMEM_ZERO_INIT_EN: after reset the array is
// zeroed one word per cycle in a CLEAR state before the loader goes IDLE.
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,

   input  logic [31:0] imem_addr_i,
   output logic [31:0] imem_rdata_o,
   output logic        fetch_fault_o,

   input  logic        load_start_i,
   input  logic [31:0] load_addr_i,
   input  logic        load_valid_i,
   input  logic [7:0]  load_byte_i,
   input  logic        load_last_i,
   output logic        load_ready_o,
   output logic        load_busy_o,
   output logic        load_done_o
);

   localparam int unsigned       ADDR_W   = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);
   // Array span in bytes; one bit wider so a 4 GiB array still compares.
   localparam logic [32:0]       SPAN     = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
`ifdef IMEM_ZERO_INIT_EN
      ,
      S_CLEAR
`endif
   } state_t;

   // --------------------------------------------------------------------------
   // Storage
   // --------------------------------------------------------------------------
   logic [31:0] mem [DEPTH_WORDS];

   // --------------------------------------------------------------------------
   // Fetch path
   // --------------------------------------------------------------------------
   logic [31:0]       fetch_off;
   logic [ADDR_W-1:0] fetch_w;
   logic [ADDR_W-1:0] fetch_w_nx;
   logic [31:0]       lo_word;
   logic [15:0]       hi_half;
   logic              fetch_in_range;
   logic              fetch_at_last;
   logic              fetch_straddle_end;

   always_comb begin
      // An address below BASE_ADDR wraps to a huge offset, so one unsigned
      // compare against the span covers both ends of the window.
      fetch_off          = imem_addr_i - BASE_ADDR;
      fetch_in_range     = ({1'b0, fetch_off} < SPAN);
      fetch_w            = ADDR_W'(fetch_off >> 2);
      fetch_w_nx         = fetch_w + ADDR_W'(1);
      fetch_at_last      = (fetch_w == LAST_IDX);
      fetch_straddle_end = imem_addr_i[1] && fetch_at_last;

      lo_word = mem[fetch_w];
      // The upper half never wraps around to word 0.
      hi_half = fetch_straddle_end ? 16'h0000 : mem[fetch_w_nx][15:0];

      if (imem_addr_i[1]) begin
         imem_rdata_o = {hi_half, lo_word[31:16]};
      end else begin
         imem_rdata_o = lo_word;
      end

      // A compressed instruction in the final straddle slot is complete;
      // only a 32-bit encoding (low bits 2'b11) is cut off.
      fetch_fault_o = imem_addr_i[0]
                   || !fetch_in_range
                   || (fetch_straddle_end && (imem_rdata_o[1:0] == 2'b11));
   end

   // --------------------------------------------------------------------------
   // Loader state
   // --------------------------------------------------------------------------
   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] word_ptr;
   logic [1:0]        byte_cnt;
   logic [3:0]        byte_mask;
   logic [31:0]       wbuf;
   logic              last_seen;
   logic              byte_acc;
   logic [31:0]       load_off;
   logic [ADDR_W-1:0] start_ptr;
`ifdef IMEM_ZERO_INIT_EN
   logic [ADDR_W-1:0] clr_idx;
`endif

   assign byte_acc  = load_valid_i && (state == S_LOAD);
   assign load_off  = load_addr_i - BASE_ADDR;
   assign start_ptr = ADDR_W'(load_off >> 2);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
`ifdef IMEM_ZERO_INIT_EN
         state <= S_CLEAR;
`else
         state <= S_IDLE;
`endif
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      load_ready_o = 1'b0;
      load_busy_o  = 1'b1;
      load_done_o  = 1'b0;
      case (state)
         S_IDLE: begin
            load_busy_o = 1'b0;
            if (load_start_i) begin
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            load_ready_o = 1'b1;
            if (byte_acc && ((byte_cnt == 2'd3) || load_last_i)) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            state_nx = last_seen ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            load_done_o = 1'b1;
            state_nx    = S_IDLE;
         end
`ifdef IMEM_ZERO_INIT_EN
         S_CLEAR: begin
            if (clr_idx == LAST_IDX) begin
               state_nx = S_IDLE;
            end
         end
`endif
         default: begin
            load_busy_o = 1'b0;
            state_nx    = S_IDLE;
         end
      endcase
   end

   // Datapath registers of the loader.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         word_ptr  <= '0;
         byte_cnt  <= '0;
         byte_mask <= '0;
         wbuf      <= '0;
         last_seen <= 1'b0;
`ifdef IMEM_ZERO_INIT_EN
         clr_idx   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (load_start_i) begin
                  word_ptr  <= start_ptr;
                  byte_cnt  <= '0;
                  byte_mask <= '0;
                  last_seen <= 1'b0;
               end
            end
            S_LOAD: begin
               if (byte_acc) begin
                  wbuf[{byte_cnt, 3'b000} +: 8] <= load_byte_i;
                  byte_mask[byte_cnt]           <= 1'b1;
                  byte_cnt                      <= byte_cnt + 2'd1;
                  if (load_last_i) begin
                     last_seen <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               // Power-of-two depth: natural overflow wraps to word 0.
               word_ptr  <= word_ptr + ADDR_W'(1);
               byte_cnt  <= '0;
               byte_mask <= '0;
            end
`ifdef IMEM_ZERO_INIT_EN
            S_CLEAR: begin
               clr_idx <= clr_idx + ADDR_W'(1);
            end
`endif
            default: begin
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Array write port
   // --------------------------------------------------------------------------
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   // Writes are suppressed while reset is asserted so a session interrupted
   // by reset never commits its partial word.
   always_comb begin
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_waddr = word_ptr;
      mem_wdata = wbuf;
      if (rst_n_i) begin
         if (state == S_WRITE) begin
            mem_we = 1'b1;
            mem_be = byte_mask;
         end
`ifdef IMEM_ZERO_INIT_EN
         if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_waddr = clr_idx;
            mem_wdata = '0;
         end
`endif
      end
   end

   // Byte-lane write; unmasked lanes keep their previous contents.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
               mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Self-checking bench for imem_responder with a 16-word array at 0x100.
// Words are loaded through the byte loader, then a table of fetch vectors
// is applied; loader corners (wrap, collision, partial mask, mid-session
// reset) are hand-written sequences.  Honours IMEM_ZERO_INIT_EN.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        fetch_fault;
   logic        load_start;
   logic [31:0] load_addr;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic        load_ready;
   logic        load_busy;
   logic        load_done;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   imem_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .imem_addr_i   (imem_addr),
      .imem_rdata_o  (imem_rdata),
      .fetch_fault_o (fetch_fault),
      .load_start_i  (load_start),
      .load_addr_i   (load_addr),
      .load_valid_i  (load_valid),
      .load_byte_i   (load_byte),
      .load_last_i   (load_last),
      .load_ready_o  (load_ready),
      .load_busy_o   (load_busy),
      .load_done_o   (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        fault;
   } fetch_vec_t;

   fetch_vec_t vecs [13];

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string nm);
      int unsigned cyc;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_start = 1'b0;
      rst_n      = 1'b0;
      tick();
      tick();
      check1({nm, "_ready"}, load_ready, 1'b0);
      check1({nm, "_done"},  load_done,  1'b0);
`ifdef IMEM_ZERO_INIT_EN
      check1({nm, "_busy"},  load_busy,  1'b1);
`else
      check1({nm, "_busy"},  load_busy,  1'b0);
`endif
      rst_n = 1'b1;
`ifdef IMEM_ZERO_INIT_EN
      cyc = 0;
      while (load_busy && cyc < DEPTH + 8) begin
         tick();
         cyc++;
      end
      check32({nm, "_clear_cycles"}, cyc, DEPTH);
      check1({nm, "_clear_ready"}, load_ready, 1'b0);
`else
      cyc = 0;
`endif
   endtask

   task automatic start_session(input logic [31:0] a);
      load_start = 1'b1;
      load_addr  = a;
      tick();
      load_start = 1'b0;
      load_addr  = 32'hDEAD_BEEF;
   endtask

   // Sends n bytes (byte i at bits[8i+:8]); returns right after the last
   // byte is accepted.  With fin=1 the last byte carries load_last.
   task automatic send_bytes(input logic [63:0] bytes, input int unsigned n, input logic fin);
      int unsigned budget;
      for (int unsigned i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_byte  = bytes[8*i +: 8];
         load_last  = fin && (i == n - 1);
         budget = 0;
         while (!load_ready && budget < 16) begin
            tick();
            budget++;
         end
         if (!load_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got 0 expected 1 (byte %0d)", i);
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic finish_session(input string nm);
      int unsigned pulses;
      pulses = 0;
      for (int unsigned i = 0; i < 6; i++) begin
         tick();
         if (load_done) pulses++;
      end
      check32({nm, "_done_pulses"}, pulses, 32'd1);
      check1({nm, "_idle_busy"}, load_busy, 1'b0);
   endtask

   task automatic load_words(input string nm, input logic [31:0] a,
                             input logic [63:0] bytes, input int unsigned n);
      start_session(a);
      send_bytes(bytes, n, 1'b1);
      finish_session(nm);
   endtask

   task automatic fetch_check(input string nm, input logic [31:0] a,
                              input logic [31:0] exp_d, input logic exp_f);
      imem_addr = a;
      #1;
      check32({nm, "_rdata"}, imem_rdata, exp_d);
      check1({nm, "_fault"}, fetch_fault, exp_f);
   endtask

   initial begin
      // addr, expected rdata, expected fault
      vecs[0]  = '{32'h0000_0110, 32'h0010_0513, 1'b0};  // full word load
      vecs[1]  = '{32'h0000_0114, 32'hAABB_2211, 1'b0};  // partial mask
      vecs[2]  = '{32'h0000_0100, 32'h1234_5678, 1'b0};  // wrapped word 0
      vecs[3]  = '{32'h0000_0102, 32'hDEF0_1234, 1'b0};  // straddle 0/1
      vecs[4]  = '{32'h0000_0101, 32'h1234_5678, 1'b1};  // odd address
      vecs[5]  = '{32'h0000_0103, 32'hDEF0_1234, 1'b1};  // odd, straddle
      vecs[6]  = '{32'h0000_013E, 32'h0000_0003, 1'b1};  // cut 32-bit at end
      vecs[7]  = '{32'h0000_013C, 32'h0003_0001, 1'b0};  // last word aligned
      vecs[8]  = '{32'h0000_0112, 32'h2211_0010, 1'b0};  // straddle 4/5
      vecs[9]  = '{32'h0000_0140, 32'h1234_5678, 1'b1};  // one past end
      vecs[10] = '{32'h0000_00FC, 32'h0003_0001, 1'b1};  // below base
      vecs[11] = '{32'h0000_0118, 32'h0403_0201, 1'b0};  // collided word
      vecs[12] = '{32'h0000_013F, 32'h0000_0003, 1'b1};  // odd at end

      rst_n      = 1'b0;
      imem_addr  = BASE;
      load_start = 1'b0;
      load_addr  = '0;
      load_valid = 1'b0;
      load_byte  = '0;
      load_last  = 1'b0;

      do_reset("reset");

      // Full word at 0x110; also confirm ready/busy while in LOAD.
      start_session(32'h0000_0110);
      check1("load_ready", load_ready, 1'b1);
      check1("load_busy",  load_busy,  1'b1);
      send_bytes(64'h0000_0000_0010_0513, 4, 1'b1);
      finish_session("full_word");

      // Preload then partially overwrite word 5.
      load_words("preload5", 32'h0000_0114, 64'h0000_0000_AABB_CCDD, 4);
      load_words("partial5", 32'h0000_0114, 64'h0000_0000_0000_2211, 2);

      // 8 bytes from the last word wrap into word 0.
      load_words("wrap", 32'h0000_013C, 64'h1234_5678_0003_0001, 8);

      // Word 1 via an unaligned start address (low bits ignored).
      load_words("word1", 32'h0000_0107, 64'h0000_0000_9ABC_DEF0, 4);

      // Read/write collision on word 6.
      load_words("preload6", 32'h0000_0118, 64'h0000_0000_CAFE_F00D, 4);
      imem_addr = 32'h0000_0118;
      start_session(32'h0000_0118);
      send_bytes(64'h0000_0000_0403_0201, 4, 1'b1);
      check32("collide_old", imem_rdata, 32'hCAFE_F00D);
      check1("collide_write_ready", load_ready, 1'b0);
      tick();
      check32("collide_new", imem_rdata, 32'h0403_0201);
      check1("collide_done", load_done, 1'b1);
      tick();
      check1("collide_done_clear", load_done, 1'b0);
      check1("collide_busy_clear", load_busy, 1'b0);

      for (int unsigned i = 0; i < 13; i++) begin
         imem_addr = vecs[i].addr;
         #1;
         n_cmp++;
         if (imem_rdata !== vecs[i].rdata) begin
            n_err++;
            $display("FAIL fetch_vec%0d_rdata addr=%h: got %h expected %h",
                     i, vecs[i].addr, imem_rdata, vecs[i].rdata);
         end
         n_cmp++;
         if (fetch_fault !== vecs[i].fault) begin
            n_err++;
            $display("FAIL fetch_vec%0d_fault addr=%h: got %b expected %b",
                     i, vecs[i].addr, fetch_fault, vecs[i].fault);
         end
      end

      // Compressed instruction in the final straddle slot does not fault.
      load_words("last_c", 32'h0000_013C, 64'h0000_0000_0001_ABCD, 4);
      fetch_check("end_compressed", 32'h0000_013E, 32'h0000_0001, 1'b0);

      // Mid-session reset after 2 bytes of word 2.
      load_words("preload2", 32'h0000_0108, 64'h0000_0000_5A5A_5A5A, 4);
      start_session(32'h0000_0108);
      send_bytes(64'h0000_0000_0000_FFEE, 2, 1'b0);
      check1("mid_in_load", load_ready, 1'b1);
      do_reset("mid_reset");
`ifdef IMEM_ZERO_INIT_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fetch_check($sformatf("zero_w%0d", i), BASE + 32'(4 * i), 32'h0, 1'b0);
      end
`else
      fetch_check("mid_word2", 32'h0000_0108, 32'h5A5A_5A5A, 1'b0);
      tick();
      check1("mid_idle_busy",  load_busy,  1'b0);
      check1("mid_idle_ready", load_ready, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
